instruction_encoder: RTL and testbench

Sequential RISC-V instruction encoder: the inverse of the immediate generation path. It accepts field-level requests (format, registers, funct3, 64-bit signed immediate) over a valid/ready handshake, range-checks and packs them into 32-bit I/S/B-type words, and writes them to consecutive word addresses of the instruction memory. It is used by the test/boot loader to build programs for the datapath without hand-assembled hex.

---
 rtl/instruction_encoder.sv | 229 ++++++++++++++++++++++
 tb/tb_instruction_encoder.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// instruction_encoder: packs I/S/B field requests into RISC-V words and
// streams them into instruction memory. Range checks: INSTRUCTION_ENCODER_RANGE_CHECK_EN.
module instruction_encoder #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_fmt,
  input  logic                  in_kind,
  input  logic [2:0]            in_funct3,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [63:0]           in_imm,
  input  logic                  clear_err,
  input  logic                  flush,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  full,
  output logic                  err,
  output logic [1:0]            err_code
);

`ifdef INSTRUCTION_ENCODER_RANGE_CHECK_EN
  localparam int IMM_W = 64;
`else
  // Only the field bits survive truncation.
  localparam int IMM_W = 13;
`endif

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] FMT_I = 2'b00;
  localparam logic [1:0] FMT_S = 2'b01;
  localparam logic [1:0] FMT_B = 2'b10;
  localparam logic [1:0] FMT_R = 2'b11;

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_RANGE = 2'b01;
  localparam logic [1:0] E_ODD   = 2'b10;
  localparam logic [1:0] E_FMT   = 2'b11;

  localparam logic [ADDR_WIDTH-1:0] PTR_STEP =
    ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST =
    ~ADDR_WIDTH'(3);

  typedef enum logic [1:0] {
    IDLE,
    ENCODE,
    WRITE,
    ERROR
  } state_t;

  typedef struct packed {
    logic [1:0]       fmt;
    logic             kind;
    logic [2:0]       funct3;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [IMM_W-1:0] imm;
  } req_t;

  state_t                  state_q, state_n;
  req_t                    req_q, req_n;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_n;
  logic                    full_q, full_n;
  logic                    err_q, err_n;
  logic                    we_q, we_n;
  logic [1:0]              code_q, code_n;
  logic [31:0]             wdata_q, wdata_n;
  logic [31:0]             word;
  logic [1:0]              chk_code;
  logic                    is_i, is_s, is_b, is_r;

`ifdef INSTRUCTION_ENCODER_RANGE_CHECK_EN
  logic fits_is, fits_b;

  assign fits_is = (&req_q.imm[63:11])
                 | ~(|req_q.imm[63:11]);
  assign fits_b  = (&req_q.imm[63:12])
                 | ~(|req_q.imm[63:12]);
`else
  logic unused_imm;

  assign unused_imm = ^in_imm[63:IMM_W];
`endif

  assign is_i = req_q.fmt == FMT_I;
  assign is_s = req_q.fmt == FMT_S;
  assign is_b = req_q.fmt == FMT_B;
  assign is_r = req_q.fmt == FMT_R;

  always_comb begin
    word = '0;
    unique case (1'b1)
      is_i: word = {
        req_q.imm[11:0], req_q.rs1,
        req_q.funct3, req_q.rd,
        req_q.kind ? OP_ADDI : OP_LOAD
      };
      is_s: word = {
        req_q.imm[11:5], req_q.rs2,
        req_q.rs1, req_q.funct3,
        req_q.imm[4:0], OP_STORE
      };
      is_b: word = {
        req_q.imm[12], req_q.imm[10:5],
        req_q.rs2, req_q.rs1,
        req_q.funct3, req_q.imm[4:1],
        req_q.imm[11], OP_BRANCH
      };
      is_r: word = '0;
      default: word = '0;
    endcase
  end

  // First failing check wins.
  always_comb begin
    chk_code = E_NONE;
    if (is_r)
      chk_code = E_FMT;
`ifdef INSTRUCTION_ENCODER_RANGE_CHECK_EN
    else if (is_b && req_q.imm[0])
      chk_code = E_ODD;
    else if (!is_b && !fits_is)
      chk_code = E_RANGE;
    else if (is_b && !fits_b)
      chk_code = E_RANGE;
`endif
  end

  always_comb begin
    state_n = state_q;
    req_n   = req_q;
    ptr_n   = ptr_q;
    full_n  = full_q;
    err_n   = err_q;
    code_n  = code_q;
    wdata_n = wdata_q;
    we_n    = 1'b0;
    if (flush) begin
      state_n = IDLE;
      ptr_n   = '0;
      full_n  = 1'b0;
      err_n   = 1'b0;
      code_n  = E_NONE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            req_n.fmt    = in_fmt;
            req_n.kind   = in_kind;
            req_n.funct3 = in_funct3;
            req_n.rd     = in_rd;
            req_n.rs1    = in_rs1;
            req_n.rs2    = in_rs2;
            req_n.imm    = in_imm[IMM_W-1:0];
            state_n      = ENCODE;
          end
        end
        ENCODE: begin
          wdata_n = word;
          if (chk_code == E_NONE) begin
            we_n    = 1'b1;
            state_n = WRITE;
          end else begin
            err_n   = 1'b1;
            code_n  = chk_code;
            state_n = ERROR;
          end
        end
        WRITE: begin
          ptr_n   = ptr_q + PTR_STEP;
          state_n = IDLE;
          if (ptr_q == PTR_LAST)
            full_n = 1'b1;
        end
        ERROR: begin
          if (clear_err) begin
            err_n   = 1'b0;
            code_n  = E_NONE;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      ptr_q   <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= E_NONE;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      req_q   <= req_n;
      ptr_q   <= ptr_n;
      full_q  <= full_n;
      err_q   <= err_n;
      code_q  <= code_n;
      wdata_q <= wdata_n;
      we_q    <= we_n;
    end
  end

  // A flush landing in WRITE suppresses that cycle's strobe.
  assign mem_we    = we_q & ~flush;
  assign in_ready  = (state_q == IDLE) & ~full_q;
  assign mem_addr  = ptr_q;
  assign mem_wdata = wdata_q;
  assign full      = full_q;
  assign err       = err_q;
  assign err_code  = code_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: randomized scoreboard bench for
// instruction_encoder with a field-arithmetic reference model.
module tb_instruction_encoder;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_fmt = '0;
  logic          in_kind = 1'b0;
  logic [2:0]    in_funct3 = '0;
  logic [4:0]    in_rd = '0;
  logic [4:0]    in_rs1 = '0;
  logic [4:0]    in_rs2 = '0;
  logic [63:0]   in_imm = '0;
  logic          clear_err = 1'b0;
  logic          flush = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          full;
  logic          err;
  logic [1:0]    err_code;

  instruction_encoder #(.ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_fmt(in_fmt),
    .in_kind(in_kind),
    .in_funct3(in_funct3),
    .in_rd(in_rd),
    .in_rs1(in_rs1),
    .in_rs2(in_rs2),
    .in_imm(in_imm),
    .clear_err(clear_err),
    .flush(flush),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .full(full),
    .err(err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_err;
    logic [1:0]    code;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   mptr = 0;
  bit   mfull = 0;
  logic perr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, req);
    end
  endtask

  function automatic logic [1:0] mcode(
      input int fmt, input longint imm);
    if (fmt == 3) return 2'b11;
`ifdef INSTRUCTION_ENCODER_RANGE_CHECK_EN
    if (fmt == 2 && (imm % 2) != 0) return 2'b10;
    if (fmt != 2 && (imm < -2048 || imm > 2047))
      return 2'b01;
    if (fmt == 2 && (imm < -4096 || imm > 4095))
      return 2'b01;
`endif
    return 2'b00;
  endfunction

  function automatic logic [31:0] mword(
      input int fmt, input int kind, input int f3,
      input int rd, input int rs1, input int rs2,
      input longint imm);
    longint w;
    longint regs;
    regs = (longint'(rs1) << 15) | (longint'(f3) << 12);
    case (fmt)
      0: w = ((imm & 'hFFF) << 20) | regs
           | (longint'(rd) << 7)
           | (kind != 0 ? 'h13 : 'h03);
      1: w = (((imm >> 5) & 'h7F) << 25)
           | (longint'(rs2) << 20) | regs
           | ((imm & 'h1F) << 7) | 'h23;
      2: w = (((imm >> 12) & 1) << 31)
           | (((imm >> 5) & 'h3F) << 25)
           | (longint'(rs2) << 20) | regs
           | (((imm >> 1) & 'hF) << 8)
           | (((imm >> 11) & 1) << 7) | 'h63;
      default: w = 0;
    endcase
    return w[31:0];
  endfunction

  task automatic drive(input int fmt, input int kind,
                       input int f3, input int rd,
                       input int rs1, input int rs2,
                       input longint imm);
    in_fmt    = 2'(fmt);
    in_kind   = 1'(kind);
    in_funct3 = 3'(f3);
    in_rd     = 5'(rd);
    in_rs1    = 5'(rs1);
    in_rs2    = 5'(rs2);
    in_imm    = imm;
    in_valid  = 1'b1;
  endtask

  task automatic push_exp(input int fmt, input int kind,
                          input int f3, input int rd,
                          input int rs1, input int rs2,
                          input longint imm,
                          input bit use_g,
                          input logic [31:0] g,
                          output bit is_err);
    exp_t e;
    e.code   = mcode(fmt, imm);
    e.is_err = e.code != 2'b00;
    e.addr   = AW'(mptr);
    e.data   = use_g ? g
             : mword(fmt, kind, f3, rd, rs1, rs2, imm);
    e.cyc    = cyc + 2;
    q.push_back(e);
    is_err = e.is_err;
    if (!e.is_err) begin
      mptr += 4;
      if (mptr == 2 ** AW) begin
        mptr  = 0;
        mfull = 1;
      end
    end
  endtask

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=0 required=1");
    end
  endtask

  task automatic issue(input int fmt, input int kind,
                       input int f3, input int rd,
                       input int rs1, input int rs2,
                       input longint imm,
                       input bit use_g = 0,
                       input logic [31:0] g = '0);
    bit ok;
    bit is_err;
    logic [AW-1:0] a;
    @(negedge clk);
    drive(fmt, kind, f3, rd, rs1, rs2, imm);
    wait_ready(ok);
    if (!ok) begin
      in_valid = 1'b0;
      return;
    end
    a = AW'(mptr);
    push_exp(fmt, kind, f3, rd, rs1, rs2, imm,
             use_g, g, is_err);
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (is_err) begin
      @(negedge clk);
      @(negedge clk);
      chk("err_in_ready", in_ready, 0);
      chk("err_mem_addr", mem_addr, a);
      clear_err = 1'b1;
      @(posedge clk);
      #1 clear_err = 1'b0;
      @(negedge clk);
      chk("clear_err", {err, err_code}, 0);
    end
  endtask

  task automatic accept_raw();
    bit ok;
    @(negedge clk);
    drive(0, 1, 0, 3, 4, 0, 17);
    wait_ready(ok);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic do_flush();
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    mptr  = 0;
    mfull = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      perr = 1'b0;
    end else begin
      if (mem_we) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write addr=%0h data=%h",
                   mem_addr, mem_wdata);
        end else begin
          e = q.pop_front();
          chk("write_expected", e.is_err, 0);
          chk("write_addr", mem_addr, e.addr);
          chk("write_data", mem_wdata, e.data);
          chk("write_cycle", cyc, e.cyc);
        end
      end
      if (err && !perr) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_err code=%0d", err_code);
        end else begin
          e = q.pop_front();
          chk("err_expected", e.is_err, 1);
          chk("err_code", err_code, e.code);
          chk("err_cycle", cyc, e.cyc);
        end
      end
      perr = err;
    end
  end

  function automatic longint pick_imm();
    longint tbl[10] = '{-4097, -4096, -2049, -2048,
                        2047, 2048, 4095, 4096, -1, 0};
    case ($urandom_range(0, 4))
      0: return longint'($urandom_range(0, 32)) - 16;
      1: return tbl[$urandom_range(0, 9)];
      2: return {$urandom, $urandom};
      3: return longint'($urandom_range(0, 8200)) - 4100;
      default:
        return (longint'($urandom_range(0, 4000)) - 2000) * 2;
    endcase
  endfunction

  initial begin
    bit ok;
    bit is_err;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_flags", {full, err, err_code}, 0);
    reset = 1'b0;

    issue(0, 1, 0, 5, 1, 0, -1, 1, 32'hFFF08293);
    issue(1, 0, 2, 0, 3, 2, 8, 1, 32'h0021A423);
    issue(2, 0, 0, 0, 1, 2, -4, 1, 32'hFE208EE3);

    do_flush();
    issue(0, 1, 0, 5, 1, 0, 2048);
    issue(2, 0, 0, 0, 1, 2, 3);
    issue(3, 0, 1, 2, 3, 4, 0);

    do_flush();
    for (int i = 0; i < 4; i++)
      issue(0, 1, $urandom_range(0, 7), i + 1, 2,
            0, longint'($urandom_range(0, 100)));
    repeat (3) @(negedge clk);
    chk("full_set", full, 1);
    chk("full_addr", mem_addr, 0);
    chk("full_ready", in_ready, 0);
    drive(0, 0, 2, 7, 8, 0, 40);
    repeat (6) begin
      @(negedge clk);
      chk("held_off", in_ready, 0);
    end
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    mptr  = 0;
    mfull = 0;
    @(negedge clk);
    chk("flush_full", full, 0);
    chk("flush_ready", in_ready, 1);
    chk("flush_addr", mem_addr, 0);
    push_exp(0, 0, 2, 7, 8, 0, 40, 0, '0, is_err);
    @(posedge clk);
    #1 in_valid = 1'b0;

    issue(0, 1, 0, 1, 1, 0, 5);
    accept_raw();
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    mptr = 0;
    @(negedge clk);
    chk("fenc_we", mem_we, 0);
    chk("fenc_addr", mem_addr, 0);
    chk("fenc_idle", in_ready, 1);

    issue(1, 0, 3, 0, 9, 10, -7);
    accept_raw();
    @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("fwr_we", mem_we, 0);
    @(posedge clk);
    #1 flush = 1'b0;
    mptr = 0;
    @(negedge clk);
    chk("fwr_addr", mem_addr, 0);
    chk("fwr_idle", in_ready, 1);

    issue(2, 0, 1, 0, 5, 6, 64);
    accept_raw();
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rwr_we", mem_we, 0);
    chk("rwr_addr", mem_addr, 0);
    chk("rwr_idle", in_ready, 1);
    @(posedge clk);
    #1 reset = 1'b0;
    mptr  = 0;
    mfull = 0;

    repeat (60) begin
      int r;
      int fmt;
      if (mfull) do_flush();
      r   = $urandom_range(0, 9);
      fmt = r < 3 ? 0 : (r < 6 ? 1 : (r < 9 ? 2 : 3));
      issue(fmt, $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 31),
            pick_imm());
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=done");
    $fatal(1, "timeout");
  end

endmodule
